// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: FSM states and loader byte width.
package mem_responder_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD_HI = 2'd1;
    localparam logic [1:0] ST_LOAD_LO = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        LOAD_HI = ST_LOAD_HI,
        LOAD_LO = ST_LOAD_LO,
        RUN     = ST_RUN
    } state_t;

endpackage

// File: rtl/sp_ram16.sv
// Single-port synchronous RAM with registered read data, read-before-write.
module sp_ram16 #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Every enabled cycle reads; a simultaneous write returns the old word.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// CPU-facing memory responder: owns the RAM, serves CPU accesses in RUN and
// fills RAM from a byte-stream loader while holding the CPU in reset.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_en,
    input  logic                  mem_rd_en,
    input  logic                  mem_wr_en,
    input  logic [ADDR_WIDTH-1:0] addr_cpu2mem,
    input  logic [DATA_WIDTH-1:0] data_cpu2mem,
    output logic [DATA_WIDTH-1:0] data_mem2cpu,
    input  logic                  i_1_ld_start,
    input  logic                  i_1_run,
    input  logic [ADDR_WIDTH:0]   i_R_ld_len,
    input  logic [BYTE_W-1:0]     i_8_ld_data,
    input  logic                  i_1_ld_valid,
    output logic                  o_1_ld_ready,
    output logic                  o_1_ld_done,
    output logic                  o_1_cpu_hold
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  state, state_n;
    logic [ADDR_WIDTH:0]     len_q, wptr_q, len_clamped;
    logic [BYTE_W-1:0]       hi_q;
    logic                    done_n, ld_we, accept, start_take, cpu_ok;
    logic                    rd_q;
    logic [DATA_WIDTH-1:0]   held_q;
    logic                    ram_en, ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_wdata, ram_rdata;

    assign len_clamped = (i_R_ld_len > DEPTH_L) ? DEPTH_L : i_R_ld_len;
    assign accept      = i_1_ld_valid & o_1_ld_ready;
    assign start_take  = i_1_ld_start & ((state == IDLE) | (state == RUN));

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        ld_we   = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (i_1_ld_start) begin
                    if (len_clamped == '0) begin
                        state_n = RUN;
                        done_n  = 1'b1;
                    end else begin
                        state_n = LOAD_HI;
                    end
                end else if (i_1_run) begin
                    state_n = RUN;
                end
            end
            LOAD_HI: begin
                if (accept) state_n = LOAD_LO;
            end
            LOAD_LO: begin
                if (accept) begin
                    ld_we = 1'b1;
                    if (wptr_q == len_q - 1'b1) begin
                        state_n = RUN;
                        done_n  = 1'b1;
                    end else begin
                        state_n = LOAD_HI;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            o_1_ld_ready <= 1'b0;
            o_1_ld_done  <= 1'b0;
            o_1_cpu_hold <= 1'b1;
            len_q        <= '0;
            wptr_q       <= '0;
            hi_q         <= '0;
            rd_q         <= 1'b0;
            held_q       <= '0;
        end else begin
            state        <= state_n;
            o_1_ld_ready <= (state_n == LOAD_HI) | (state_n == LOAD_LO);
            o_1_ld_done  <= done_n;
            o_1_cpu_hold <= (state_n != RUN);
            rd_q         <= cpu_ok & mem_rd_en;
            held_q       <= data_mem2cpu;
            if (start_take) begin
                len_q  <= len_clamped;
                wptr_q <= '0;
            end else if (ld_we) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (state == LOAD_HI && accept) begin
                hi_q <= i_8_ld_data;
            end
        end
    end

    // The FSM state decides who owns the RAM port; loader and CPU never overlap.
    assign cpu_ok    = (state == RUN) & mem_en;
    assign ram_en    = ld_we | (cpu_ok & (mem_rd_en | mem_wr_en));
    assign ram_we    = ld_we | (cpu_ok & mem_wr_en);
    assign ram_addr  = ld_we ? wptr_q[ADDR_WIDTH-1:0] : addr_cpu2mem;
    assign ram_wdata = ld_we ? {hi_q, i_8_ld_data} : data_cpu2mem;

    // Fresh RAM data only after a CPU read; otherwise hold, and zero outside RUN.
    always_comb begin
        data_mem2cpu = '0;
        if (state == RUN) begin
            data_mem2cpu = rd_q ? ram_rdata : held_q;
        end
    end

    sp_ram16 #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expectations, a negedge
// monitor pops and compares against what the DUT presents.
module tb_mem_responder;

    localparam int AW    = 6;
    localparam int LW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_en = 1'b0, mem_rd_en = 1'b0, mem_wr_en = 1'b0;
    logic [AW-1:0] addr_cpu2mem = '0;
    logic [15:0]   data_cpu2mem = '0;
    logic [15:0]   data_mem2cpu;
    logic          i_1_ld_start = 1'b0, i_1_run = 1'b0, i_1_ld_valid = 1'b0;
    logic [LW-1:0] i_R_ld_len = '0;
    logic [7:0]    i_8_ld_data = '0;
    logic          o_1_ld_ready, o_1_ld_done, o_1_cpu_hold;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .mem_en(mem_en), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .addr_cpu2mem(addr_cpu2mem), .data_cpu2mem(data_cpu2mem),
        .data_mem2cpu(data_mem2cpu),
        .i_1_ld_start(i_1_ld_start), .i_1_run(i_1_run), .i_R_ld_len(i_R_ld_len),
        .i_8_ld_data(i_8_ld_data), .i_1_ld_valid(i_1_ld_valid),
        .o_1_ld_ready(o_1_ld_ready), .o_1_ld_done(o_1_ld_done),
        .o_1_cpu_hold(o_1_cpu_hold)
    );

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    int          tests = 0;
    int          fails = 0;
    chk_t        chk_q[$];
    logic [15:0] rd_exp_q[$];
    int          done_q[$];
    logic [15:0] model [int];
    logic [7:0]  ld_bytes[$];
    int          bytes_acc = 0;
    logic        rd_issue = 1'b0;
    logic        rd_pend = 1'b0;

    function automatic void cmp(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    always @(posedge clk) rd_pend <= rd_issue;

    // Monitor: all comparisons happen here.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_exp_q.size() == 0) cmp("rd_unexpected", 32'd1, 32'd0);
            else cmp("rd_data", {16'h0, data_mem2cpu}, {16'h0, rd_exp_q.pop_front()});
        end
        if (o_1_ld_done === 1'b1) begin
            if (done_q.size() == 0) cmp("done_unexpected", 32'd1, 32'd0);
            else begin
                cmp("done_bytes", bytes_acc, done_q.pop_front());
                cmp("hold_at_done", {31'h0, o_1_cpu_hold}, 32'd0);
            end
        end
        while (chk_q.size() != 0) begin
            chk_t c;
            c = chk_q.pop_front();
            cmp(c.name, c.act, c.exp);
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        chk_t c;
        c.name = n; c.act = a; c.exp = e;
        chk_q.push_back(c);
    endtask

    task automatic cpu_clear();
        mem_en = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0; rd_issue = 1'b0;
    endtask

    // One CPU cycle in RUN; expected read data is the model word before any write.
    task automatic cpu_op(input bit en, input bit rd, input bit wr, input int a,
                          input logic [15:0] d);
        mem_en = en; mem_rd_en = rd; mem_wr_en = wr;
        addr_cpu2mem = AW'(a); data_cpu2mem = d;
        rd_issue = en & rd;
        if (en && rd) rd_exp_q.push_back(model[a]);
        if (en && wr) model[a] = d;
        @(negedge clk);
        cpu_clear();
    endtask

    task automatic garbage();
        mem_en = 1'($urandom); mem_rd_en = 1'($urandom); mem_wr_en = 1'b1;
        addr_cpu2mem = '0; data_cpu2mem = 16'($urandom); rd_issue = 1'b0;
    endtask

    // mode 0: valid always high, 1: random gaps, 2: 10-cycle stall before byte 1.
    task automatic load(input int len_req, input int nfeed, input int mode);
        int len_eff, tries, gap;
        logic [7:0] hi, b8;
        bit acc;
        len_eff = (len_req > DEPTH) ? DEPTH : len_req;
        while (ld_bytes.size() < nfeed) ld_bytes.push_back(8'($urandom));
        i_1_ld_start = 1'b1; i_R_ld_len = LW'(len_req); bytes_acc = 0;
        if (nfeed >= 2 * len_eff) done_q.push_back(2 * len_eff);
        @(negedge clk);
        i_1_ld_start = 1'b0;
        hi = '0;
        for (int b = 0; b < nfeed; b++) begin
            b8  = ld_bytes[b];
            gap = (mode == 1) ? int'($urandom_range(0, 2)) : ((mode == 2 && b == 1) ? 10 : 0);
            for (int g = 0; g < gap; g++) begin
                i_1_ld_valid = 1'b0; garbage();
                chk("ready_in_stall", {31'h0, o_1_ld_ready}, 32'd1);
                chk("data_in_load", {16'h0, data_mem2cpu}, 32'd0);
                @(negedge clk);
            end
            tries = 0; acc = 1'b0;
            while (!acc && tries < 20) begin
                i_1_ld_valid = 1'b1; i_8_ld_data = b8; garbage();
                chk("hold_in_load", {31'h0, o_1_cpu_hold}, 32'd1);
                chk("data_in_load", {16'h0, data_mem2cpu}, 32'd0);
                acc = o_1_ld_ready;
                @(posedge clk);
                tries++;
                if (acc) bytes_acc++;
                @(negedge clk);
            end
            if (!acc) begin
                chk("ld_accept_timeout", 32'd0, 32'd1);
                break;
            end
            if (b % 2 == 0) hi = b8;
            else model[b / 2] = {hi, b8};
        end
        i_1_ld_valid = 1'b0;
        cpu_clear();
        ld_bytes.delete();
        repeat (3) @(negedge clk);
        chk("done_missing", done_q.size(), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", {16'h0, data_mem2cpu}, 32'd0);
        chk("rst_ready", {31'h0, o_1_ld_ready}, 32'd0);
        chk("rst_done", {31'h0, o_1_ld_done}, 32'd0);
        chk("rst_hold", {31'h0, o_1_cpu_hold}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold", {31'h0, o_1_cpu_hold}, 32'd1);

        // Fixed 3-word load, then basic reads/writes.
        ld_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        load(3, 6, 0);
        chk("run_hold", {31'h0, o_1_cpu_hold}, 32'd0);
        cpu_op(1, 1, 0, 1, 16'h0);
        cpu_op(1, 0, 1, 5, 16'hBEEF);
        cpu_op(1, 1, 0, 5, 16'h0);
        cpu_op(1, 1, 1, 0, 16'h0F0F);
        cpu_op(1, 1, 0, 0, 16'h0);
        cpu_op(0, 1, 1, 5, 16'h1111);
        repeat (2) @(negedge clk);
        chk("data_holds", {16'h0, data_mem2cpu}, 32'h0F0F);
        cpu_op(1, 1, 0, 5, 16'h0);
        cpu_op(1, 1, 0, 2, 16'h0);

        // Bytes offered in RUN are not consumed.
        i_1_ld_valid = 1'b1; i_8_ld_data = 8'hEE;
        repeat (3) begin
            chk("ready_in_run", {31'h0, o_1_ld_ready}, 32'd0);
            @(negedge clk);
        end
        i_1_ld_valid = 1'b0;

        // Loader stall between hi and lo bytes.
        load(2, 4, 2);
        cpu_op(1, 1, 0, 0, 16'h0);
        cpu_op(1, 1, 0, 1, 16'h0);
        cpu_op(1, 1, 0, 2, 16'h0);

        // Reset after 3 bytes of a 4-word load.
        load(4, 3, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_hold", {31'h0, o_1_cpu_hold}, 32'd1);
        chk("midrst_ready", {31'h0, o_1_ld_ready}, 32'd0);
        chk("midrst_data", {16'h0, data_mem2cpu}, 32'd0);
        i_1_run = 1'b1;
        @(negedge clk);
        i_1_run = 1'b0;
        chk("run_after_rst", {31'h0, o_1_cpu_hold}, 32'd0);
        cpu_op(1, 1, 0, 0, 16'h0);
        cpu_op(1, 1, 0, 1, 16'h0);

        // Zero length load.
        load(0, 0, 0);
        chk("zero_len_hold", {31'h0, o_1_cpu_hold}, 32'd0);
        cpu_op(1, 1, 0, 0, 16'h0);
        cpu_op(1, 1, 0, 5, 16'h0);

        // Start and run together in IDLE: the load wins; run is ignored during load.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_1_run = 1'b1;
        load(1, 2, 1);
        i_1_run = 1'b0;
        cpu_op(1, 1, 0, 0, 16'h0);

        // Over-long length is clamped to DEPTH.
        load(DEPTH + 5, 2 * DEPTH, 1);
        for (int a = 0; a < DEPTH; a++) cpu_op(1, 1, 0, a, 16'h0);

        // Random CPU traffic against the model.
        repeat (200) begin
            cpu_op(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, DEPTH - 1)), 16'($urandom));
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the CPU memory port. It owns the single-port 16-bit RAM, serves CPU fetch, load and store requests with one-cycle registered read latency, and hosts a byte-stream program loader. While the loader runs, the CPU is held in reset through a hold output, and the loader fills RAM from address 0 before releasing the CPU.

Parameters:
ADDR_WIDTH, 12, word-address width; RAM depth DEPTH = 2**ADDR_WIDTH words.
DATA_WIDTH, 16, RAM word width; fixed at 16, since the loader assembles exactly 2 bytes per word.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active HIGH
mem_en  input  1  CPU memory enable
mem_rd_en  input  1  CPU read enable
mem_wr_en  input  1  CPU write enable
addr_cpu2mem  input  ADDR_WIDTH  CPU word address
data_cpu2mem  input  16  CPU write data
data_mem2cpu  output  16  registered read data to CPU
i_1_ld_start  input  1  pulse: begin program load
i_1_run  input  1  pulse: leave IDLE without loading
i_R_ld_len  input  ADDR_WIDTH+1  number of 16-bit words to load, sampled on start
i_8_ld_data  input  8  loader byte
i_1_ld_valid  input  1  loader byte valid
o_1_ld_ready  output  1  responder accepts a byte
o_1_ld_done  output  1  one-cycle pulse when the load completes
o_1_cpu_hold  output  1  HIGH holds the CPU in reset; top ORs it with rst

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset state and outputs:
  - state = IDLE
  - data_mem2cpu = 16'h0000, o_1_ld_ready = 0, o_1_ld_done = 0, o_1_cpu_hold = 1
  - word pointer = 0
  - RAM array is NOT reset; contents survive rst.
- FSM states: IDLE, LOAD_HI, LOAD_LO, RUN. All outputs are registered.
- IDLE:
  - i_1_ld_start -> LOAD_HI; latch len = min(i_R_ld_len, DEPTH); wptr = 0.
  - else i_1_run -> RUN.
  - If both are asserted in the same cycle, ld_start wins.
- Zero length: i_1_ld_start with len == 0 -> RUN directly, with o_1_ld_done pulsed.
- LOAD_HI:
  - o_1_ld_ready = 1.
  - On valid & ready, latch hi byte -> LOAD_LO.
- LOAD_LO:
  - o_1_ld_ready = 1.
  - On valid & ready, write {hi, i_8_ld_data} to RAM[wptr] (big-endian); wptr++.
  - If wptr == len-1 -> RUN and pulse o_1_ld_done for 1 cycle; else -> LOAD_HI.
- Stalls: with valid low, state holds indefinitely. Bytes offered while ready is 0 are not consumed.
- RUN:
  - o_1_cpu_hold = 0, effective the cycle after entering RUN (same cycle as o_1_ld_done).
  - i_1_ld_start -> LOAD_HI; o_1_cpu_hold = 1 from the next cycle.
- Ignored inputs:
  - i_1_ld_start during LOAD_HI/LOAD_LO is ignored.
  - i_1_run outside IDLE is ignored.
- CPU port, accepted only in RUN:
  - Read: mem_en & mem_rd_en at edge N -> data_mem2cpu = RAM[addr] after edge N+1 (1-cycle latency).
  - With no read, data_mem2cpu holds its last value.
  - Write: mem_en & mem_wr_en -> RAM[addr] <= data_cpu2mem.
  - mem_en = 0 masks both rd and wr.
  - rd & wr to the same address in one cycle: the write commits and the read returns OLD data (read-before-write).
- CPU port outside RUN: CPU requests are ignored (no RAM write) and data_mem2cpu is forced to 16'h0000.
- Length clamp: i_R_ld_len > DEPTH is clamped to DEPTH. A load of DEPTH words fills addresses 0..DEPTH-1 and does not wrap.
- Reset mid-load: the FSM returns to IDLE and a partially assembled word is discarded. Words already written remain in RAM.
- RAM port sharing: the loader and the CPU never access RAM in the same cycle; the FSM state selects the RAM port owner.

Decomposition:
- Package mem_responder_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_LOAD_HI=2'd1, ST_LOAD_LO=2'd2, ST_RUN=2'd3
  - BYTE_W = 8
- Sub-module sp_ram16:
  - single-port synchronous RAM, parameters ADDR_WIDTH/DATA_WIDTH
  - ports en, we, addr, wdata, rdata; read-before-write
  - registered rdata
- The top holds the FSM, byte assembly, word pointer and the port-owner mux.

Test Plan:
1. Reset, then ld_start with len=3, bytes 12 34 56 78 9A BC (valid held high) -> RAM[0..2] = 1234, 5678, 9ABC. ld_done pulses once, 6 accepted bytes later. cpu_hold falls in the same cycle.
2. In RUN: CPU read addr 1 at edge N -> data_mem2cpu = 16'h5678 after edge N+1. CPU write addr 5 = 16'hBEEF, then read addr 5 -> 16'hBEEF.
3. Same-cycle rd+wr to addr 0 with data 16'h0F0F -> data_mem2cpu = 16'h1234 (old data). A following read returns 16'h0F0F.
4. Loader stall: valid deasserted for 10 cycles between the hi and lo bytes -> state stays LOAD_LO and the word is still written correctly. During the load, CPU mem_wr_en to addr 0 is ignored and data_mem2cpu = 0.
5. rst asserted after 3 bytes of a 4-word load -> IDLE, cpu_hold = 1, RAM[0] retains the first word and RAM[1] is unchanged. Then i_1_run -> RUN with cpu_hold = 0.
6. ld_start with len=0 -> RUN plus a done pulse, no RAM write. len=DEPTH+5 is clamped: exactly DEPTH words are written and done pulses after 2*DEPTH bytes.
